// File: rtl/stream_checker.sv
// ---------------------------------------------------------------------------
// stream_checker
//
// Two independent lanes, each a small FIFO followed by a sequence checker.
// Each popped word should be one more than the previous popped word (mod
// 2^32). The first pop after reset or flush only loads the expectation
// (UNSYNC -> SYNC). Every later pop is compared against it and then
// re-aligns to the popped word.
//
// Parameters
//   DEPTH  per-lane FIFO depth, power of two in 2..16
//   CNT_W  width of the match / mismatch statistics counters
//
// Ports (suffix _1 / _2 selects the lane)
//   clk              rising-edge clock
//   reset            synchronous, active-low reset
//   in_data_x        32-bit word from the producer
//   in_valid_x       word present (held stable while stalled)
//   in_flush_x       one-cycle flush pulse: empties FIFO, back to UNSYNC
//   drain_en_x       downstream pop enable
//   out_stall_x      FIFO full, word not accepted
//   err_x            sticky mismatch flag
//   match_cnt_x      saturating count of matching checked pops
//   mismatch_cnt_x   saturating count of mismatching checked pops
//   sync_x           lane is in SYNC
// ---------------------------------------------------------------------------

module stream_checker_lane #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  input  logic             in_flush,
  input  logic             drain_en,
  output logic             out_stall,
  output logic             err,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             sync
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {
    ST_UNSYNC = 1'b0,
    ST_SYNC   = 1'b1
  } state_t;

  logic [31:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;      // one extra bit so full and empty differ
  state_t           r_state;
  logic [31:0]      r_expected;
  logic             r_err;
  logic [CNT_W-1:0] r_match_cnt;
  logic [CNT_W-1:0] r_mismatch_cnt;

  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_head;
  state_t           w_state_nxt;
  logic             w_load;
  logic             w_check;

  assign w_full = (r_count == FULL_CNT);
  assign w_push = in_valid && !w_full && !in_flush;
  assign w_pop  = (r_count != '0) && drain_en && !in_flush;
  // The check reads the registered head, so a word pushed this cycle cannot
  // be popped before the next one.
  assign w_head = r_mem[r_rd_ptr];

  // NOTE: storage has no reset; pointers and occupancy decide which entries
  // are meaningful, so resetting the array would only add logic.
  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // NOTE: every output of this block gets a default first so that no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_check     = 1'b0;
    if (in_flush) begin
      w_state_nxt = ST_UNSYNC;
    end else if (w_pop) begin
      w_load = 1'b1;
      case (r_state)
        ST_UNSYNC: w_state_nxt = ST_SYNC;
        ST_SYNC:   w_check     = 1'b1;
        default:   w_state_nxt = ST_UNSYNC;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_state        <= ST_UNSYNC;
      r_expected     <= '0;
      r_err          <= 1'b0;
      r_match_cnt    <= '0;
      r_mismatch_cnt <= '0;
    end else begin
      if (in_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        // Pointers wrap naturally because DEPTH is a power of two.
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end

      r_state <= w_state_nxt;

      // Both the first pop and every checked pop re-align the expectation.
      if (w_load) r_expected <= w_head + 32'd1;

      if (w_check) begin
        if (w_head == r_expected) begin
          if (r_match_cnt != '1) r_match_cnt <= r_match_cnt + 1'b1;
        end else begin
          if (r_mismatch_cnt != '1) r_mismatch_cnt <= r_mismatch_cnt + 1'b1;
          r_err <= 1'b1;
        end
      end
    end
  end

  assign out_stall    = w_full;
  assign err          = r_err;
  assign match_cnt    = r_match_cnt;
  assign mismatch_cnt = r_mismatch_cnt;
  assign sync         = (r_state == ST_SYNC);

endmodule

module stream_checker #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      in_data_1,
  input  logic [31:0]      in_data_2,
  input  logic             in_valid_1,
  input  logic             in_valid_2,
  input  logic             in_flush_1,
  input  logic             in_flush_2,
  input  logic             drain_en_1,
  input  logic             drain_en_2,
  output logic             out_stall_1,
  output logic             out_stall_2,
  output logic             err_1,
  output logic             err_2,
  output logic [CNT_W-1:0] match_cnt_1,
  output logic [CNT_W-1:0] match_cnt_2,
  output logic [CNT_W-1:0] mismatch_cnt_1,
  output logic [CNT_W-1:0] mismatch_cnt_2,
  output logic             sync_1,
  output logic             sync_2
);

  stream_checker_lane #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_lane_1 (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data_1),
    .in_valid     (in_valid_1),
    .in_flush     (in_flush_1),
    .drain_en     (drain_en_1),
    .out_stall    (out_stall_1),
    .err          (err_1),
    .match_cnt    (match_cnt_1),
    .mismatch_cnt (mismatch_cnt_1),
    .sync         (sync_1)
  );

  stream_checker_lane #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_lane_2 (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data_2),
    .in_valid     (in_valid_2),
    .in_flush     (in_flush_2),
    .drain_en     (drain_en_2),
    .out_stall    (out_stall_2),
    .err          (err_2),
    .match_cnt    (match_cnt_2),
    .mismatch_cnt (mismatch_cnt_2),
    .sync         (sync_2)
  );

endmodule

// File: tb/tb_stream_checker.sv
// ---------------------------------------------------------------------------
// tb_stream_checker
//
// Directed bench for stream_checker. A main instance (DEPTH=4, CNT_W=16)
// carries the functional scenarios. A second instance (DEPTH=2, CNT_W=2)
// shares the same stimulus and is used to observe counter saturation.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------

module tb_stream_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data_1, in_data_2;
  logic        in_valid_1, in_valid_2;
  logic        in_flush_1, in_flush_2;
  logic        drain_en_1, drain_en_2;

  logic        out_stall_1, out_stall_2, err_1, err_2, sync_1, sync_2;
  logic [15:0] match_cnt_1, match_cnt_2, mismatch_cnt_1, mismatch_cnt_2;

  logic        s_stall_1, s_stall_2, s_err_1, s_err_2, s_sync_1, s_sync_2;
  logic [1:0]  s_match_1, s_match_2, s_mismatch_1, s_mismatch_2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_checker #(.DEPTH(4), .CNT_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_data_1      (in_data_1),
    .in_data_2      (in_data_2),
    .in_valid_1     (in_valid_1),
    .in_valid_2     (in_valid_2),
    .in_flush_1     (in_flush_1),
    .in_flush_2     (in_flush_2),
    .drain_en_1     (drain_en_1),
    .drain_en_2     (drain_en_2),
    .out_stall_1    (out_stall_1),
    .out_stall_2    (out_stall_2),
    .err_1          (err_1),
    .err_2          (err_2),
    .match_cnt_1    (match_cnt_1),
    .match_cnt_2    (match_cnt_2),
    .mismatch_cnt_1 (mismatch_cnt_1),
    .mismatch_cnt_2 (mismatch_cnt_2),
    .sync_1         (sync_1),
    .sync_2         (sync_2)
  );

  stream_checker #(.DEPTH(2), .CNT_W(2)) dut_sat (
    .clk            (clk),
    .reset          (reset),
    .in_data_1      (in_data_1),
    .in_data_2      (in_data_2),
    .in_valid_1     (in_valid_1),
    .in_valid_2     (in_valid_2),
    .in_flush_1     (in_flush_1),
    .in_flush_2     (in_flush_2),
    .drain_en_1     (drain_en_1),
    .drain_en_2     (drain_en_2),
    .out_stall_1    (s_stall_1),
    .out_stall_2    (s_stall_2),
    .err_1          (s_err_1),
    .err_2          (s_err_2),
    .match_cnt_1    (s_match_1),
    .match_cnt_2    (s_match_2),
    .mismatch_cnt_1 (s_mismatch_1),
    .mismatch_cnt_2 (s_mismatch_2),
    .sync_1         (s_sync_1),
    .sync_2         (s_sync_2)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    in_data_1 = '0; in_data_2 = '0;
    in_valid_1 = 1'b0; in_valid_2 = 1'b0;
    in_flush_1 = 1'b0; in_flush_2 = 1'b0;
    drain_en_1 = 1'b0; drain_en_2 = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
  endtask

  task automatic push1(input logic [31:0] d);
    in_valid_1 = 1'b1;
    in_data_1  = d;
    cyc(1);
  endtask

  task automatic push2(input logic [31:0] d1, input logic [31:0] d2);
    in_valid_1 = 1'b1; in_data_1 = d1;
    in_valid_2 = 1'b1; in_data_2 = d2;
    cyc(1);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    cyc(2);
    reset = 1'b1;
    checks++; if (out_stall_1 !== 1'b0) begin failures++; $display("FAIL reset_stall_1 got=%b exp=0", out_stall_1); end
    checks++; if (out_stall_2 !== 1'b0) begin failures++; $display("FAIL reset_stall_2 got=%b exp=0", out_stall_2); end
    checks++; if (sync_1 !== 1'b0) begin failures++; $display("FAIL reset_sync_1 got=%b exp=0", sync_1); end
    checks++; if (sync_2 !== 1'b0) begin failures++; $display("FAIL reset_sync_2 got=%b exp=0", sync_2); end
    checks++; if (err_1 !== 1'b0 || err_2 !== 1'b0) begin failures++; $display("FAIL reset_err got=%b%b exp=00", err_1, err_2); end
    checks++; if (match_cnt_1 !== 16'd0 || mismatch_cnt_1 !== 16'd0) begin failures++; $display("FAIL reset_cnt_1 got=%0d/%0d exp=0/0", match_cnt_1, mismatch_cnt_1); end
    checks++; if (match_cnt_2 !== 16'd0 || mismatch_cnt_2 !== 16'd0) begin failures++; $display("FAIL reset_cnt_2 got=%0d/%0d exp=0/0", match_cnt_2, mismatch_cnt_2); end
  endtask

  task automatic test_stream();
    do_reset();
    drain_en_1 = 1'b1;
    push1(32'd5);
    checks++; if (sync_1 !== 1'b0) begin failures++; $display("FAIL stream_sync_before_pop got=%b exp=0", sync_1); end
    push1(32'd6);
    checks++; if (sync_1 !== 1'b1) begin failures++; $display("FAIL stream_sync_after_pop got=%b exp=1", sync_1); end
    push1(32'd7);
    push1(32'd8);
    push1(32'd9);
    in_valid_1 = 1'b0;
    cyc(4);
    checks++; if (match_cnt_1 !== 16'd4) begin failures++; $display("FAIL stream_match got=%0d exp=4", match_cnt_1); end
    checks++; if (mismatch_cnt_1 !== 16'd0) begin failures++; $display("FAIL stream_mismatch got=%0d exp=0", mismatch_cnt_1); end
    checks++; if (err_1 !== 1'b0) begin failures++; $display("FAIL stream_err got=%b exp=0", err_1); end
    checks++; if (s_match_1 !== 2'd3) begin failures++; $display("FAIL sat_match got=%0d exp=3", s_match_1); end
    checks++; if (match_cnt_2 !== 16'd0 || sync_2 !== 1'b0) begin failures++; $display("FAIL stream_lane2_quiet got=%0d/%b exp=0/0", match_cnt_2, sync_2); end
  endtask

  task automatic test_full();
    do_reset();
    drain_en_1 = 1'b0;
    push1(32'd10);
    push1(32'd11);
    push1(32'd12);
    checks++; if (out_stall_1 !== 1'b0) begin failures++; $display("FAIL full_stall_at3 got=%b exp=0", out_stall_1); end
    push1(32'd13);
    in_data_1 = 32'd14;
    checks++; if (out_stall_1 !== 1'b1) begin failures++; $display("FAIL full_stall_at4 got=%b exp=1", out_stall_1); end
    cyc(2);
    checks++; if (out_stall_1 !== 1'b1) begin failures++; $display("FAIL full_stall_held got=%b exp=1", out_stall_1); end
    drain_en_1 = 1'b1;
    cyc(1);
    checks++; if (out_stall_1 !== 1'b0) begin failures++; $display("FAIL full_stall_after_pop got=%b exp=0", out_stall_1); end
    cyc(1);
    in_valid_1 = 1'b0;
    cyc(5);
    checks++; if (match_cnt_1 !== 16'd4) begin failures++; $display("FAIL full_match got=%0d exp=4", match_cnt_1); end
    checks++; if (mismatch_cnt_1 !== 16'd0 || err_1 !== 1'b0) begin failures++; $display("FAIL full_mismatch got=%0d/%b exp=0/0", mismatch_cnt_1, err_1); end
  endtask

  task automatic test_flush();
    do_reset();
    drain_en_1 = 1'b0;
    push1(32'd20);
    push1(32'd21);
    in_valid_1 = 1'b0;
    drain_en_1 = 1'b1;
    cyc(1);
    checks++; if (sync_1 !== 1'b1) begin failures++; $display("FAIL flush_sync_pre got=%b exp=1", sync_1); end
    in_flush_1 = 1'b1;
    cyc(1);
    in_flush_1 = 1'b0;
    checks++; if (sync_1 !== 1'b0) begin failures++; $display("FAIL flush_sync_post got=%b exp=0", sync_1); end
    cyc(2);
    checks++; if (sync_1 !== 1'b0) begin failures++; $display("FAIL flush_fifo_empty got=%b exp=0", sync_1); end
    push1(32'd300);
    push1(32'd301);
    in_valid_1 = 1'b0;
    cyc(3);
    checks++; if (match_cnt_1 !== 16'd1) begin failures++; $display("FAIL flush_match got=%0d exp=1", match_cnt_1); end
    checks++; if (mismatch_cnt_1 !== 16'd0 || err_1 !== 1'b0) begin failures++; $display("FAIL flush_mismatch got=%0d/%b exp=0/0", mismatch_cnt_1, err_1); end
    checks++; if (sync_1 !== 1'b1) begin failures++; $display("FAIL flush_resync got=%b exp=1", sync_1); end
  endtask

  task automatic test_mismatch();
    do_reset();
    drain_en_1 = 1'b1;
    push1(32'd40);
    push1(32'd41);
    push1(32'd43);
    push1(32'd44);
    in_valid_1 = 1'b0;
    cyc(4);
    checks++; if (mismatch_cnt_1 !== 16'd1) begin failures++; $display("FAIL mis_mismatch got=%0d exp=1", mismatch_cnt_1); end
    checks++; if (match_cnt_1 !== 16'd2) begin failures++; $display("FAIL mis_match got=%0d exp=2", match_cnt_1); end
    checks++; if (err_1 !== 1'b1) begin failures++; $display("FAIL mis_err got=%b exp=1", err_1); end
    in_flush_1 = 1'b1;
    cyc(1);
    in_flush_1 = 1'b0;
    cyc(2);
    checks++; if (err_1 !== 1'b1) begin failures++; $display("FAIL mis_err_sticky got=%b exp=1", err_1); end
    checks++; if (match_cnt_1 !== 16'd2 || mismatch_cnt_1 !== 16'd1) begin failures++; $display("FAIL mis_cnt_after_flush got=%0d/%0d exp=2/1", match_cnt_1, mismatch_cnt_1); end
  endtask

  task automatic test_wrap();
    do_reset();
    drain_en_1 = 1'b1;
    push1(32'hFFFF_FFFE);
    push1(32'hFFFF_FFFF);
    push1(32'h0000_0000);
    in_valid_1 = 1'b0;
    cyc(3);
    checks++; if (match_cnt_1 !== 16'd2) begin failures++; $display("FAIL wrap_match got=%0d exp=2", match_cnt_1); end
    checks++; if (err_1 !== 1'b0 || mismatch_cnt_1 !== 16'd0) begin failures++; $display("FAIL wrap_err got=%b/%0d exp=0/0", err_1, mismatch_cnt_1); end
  endtask

  task automatic test_saturate();
    do_reset();
    drain_en_1 = 1'b1;
    for (int k = 0; k < 6; k++) push1(32'(2 * k + 1));
    in_valid_1 = 1'b0;
    cyc(3);
    checks++; if (mismatch_cnt_1 !== 16'd5) begin failures++; $display("FAIL sat_main_mismatch got=%0d exp=5", mismatch_cnt_1); end
    checks++; if (s_mismatch_1 !== 2'd3) begin failures++; $display("FAIL sat_mismatch got=%0d exp=3", s_mismatch_1); end
    checks++; if (s_err_1 !== 1'b1) begin failures++; $display("FAIL sat_err got=%b exp=1", s_err_1); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drain_en_1 = 1'b1;
    drain_en_2 = 1'b1;
    push2(32'd7, 32'd70);
    push2(32'd8, 32'd72);
    push2(32'd9, 32'd73);
    push2(32'd10, 32'd74);
    in_valid_1 = 1'b0;
    in_valid_2 = 1'b0;
    cyc(4);
    checks++; if (match_cnt_1 !== 16'd3 || err_1 !== 1'b0) begin failures++; $display("FAIL dual_lane1 got=%0d/%b exp=3/0", match_cnt_1, err_1); end
    checks++; if (match_cnt_2 !== 16'd2) begin failures++; $display("FAIL dual_lane2_match got=%0d exp=2", match_cnt_2); end
    checks++; if (mismatch_cnt_2 !== 16'd1 || err_2 !== 1'b1) begin failures++; $display("FAIL dual_lane2_err got=%0d/%b exp=1/1", mismatch_cnt_2, err_2); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drain_en_1 = 1'b1;
    push1(32'd1);
    push1(32'd2);
    push1(32'd9);
    in_valid_1 = 1'b0;
    cyc(3);
    checks++; if (err_1 !== 1'b1 || match_cnt_1 !== 16'd1 || mismatch_cnt_1 !== 16'd1) begin failures++; $display("FAIL rmid_pre got=%b/%0d/%0d exp=1/1/1", err_1, match_cnt_1, mismatch_cnt_1); end
    drain_en_1 = 1'b0;
    push1(32'd50);
    push1(32'd51);
    push1(32'd52);
    in_valid_1 = 1'b0;
    reset = 1'b0;
    drain_en_1 = 1'b1;
    cyc(1);
    reset = 1'b1;
    drain_en_1 = 1'b0;
    checks++; if (err_1 !== 1'b0 || sync_1 !== 1'b0 || out_stall_1 !== 1'b0) begin failures++; $display("FAIL rmid_flags got=%b/%b/%b exp=0/0/0", err_1, sync_1, out_stall_1); end
    checks++; if (match_cnt_1 !== 16'd0 || mismatch_cnt_1 !== 16'd0) begin failures++; $display("FAIL rmid_cnt got=%0d/%0d exp=0/0", match_cnt_1, mismatch_cnt_1); end
    drain_en_1 = 1'b1;
    cyc(2);
    checks++; if (sync_1 !== 1'b0) begin failures++; $display("FAIL rmid_empty got=%b exp=0", sync_1); end
    push1(32'd60);
    push1(32'd61);
    in_valid_1 = 1'b0;
    cyc(3);
    checks++; if (match_cnt_1 !== 16'd1 || mismatch_cnt_1 !== 16'd0 || sync_1 !== 1'b1) begin failures++; $display("FAIL rmid_after got=%0d/%0d/%b exp=1/0/1", match_cnt_1, mismatch_cnt_1, sync_1); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_flush();
    test_mismatch();
    test_wrap();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
